// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the bit-serial sequence detector controller.
package seq_detect_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [5:0] DEFAULT_PAT = 6'b101001;

    // Width of a field able to hold a pattern length of 0..pat_w.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_matcher.sv
// History shift register, fill counter and pattern compare for the sequence detector.
// match is combinational and reflects the bit being shifted in on this edge.
module seq_matcher #(
    parameter int PAT_W = 6,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clr,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_next;

    always_comb begin
        hist_next = hist;
        fill_next = fill;
        mask      = '0;
        if (en) begin
            hist_next = {hist[PAT_W-2:0], bit_in};
            if (fill != FILL_MAX) begin
                fill_next = fill + 1'b1;
            end
        end
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        // Only the newest len bits take part, and only once that many have arrived.
        match = en && (fill_next >= len) && ((hist_next & mask) == (pattern & mask));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_next;
            fill <= fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable sequence detector controller: config registers, arm/disarm FSM,
// tone pulse and wrapping detection counter. SEQ_DETECT_CTRL_THRESH_EN adds cfg_thresh/irq.
//
//   state | meaning
//   IDLE  | disarmed, config writes accepted, history cleared
//   ARMED | qualified bits shifted and matched, config writes ignored
module seq_detect_ctrl #(
    parameter int               PAT_W       = 6,
    parameter int               CNT_W       = 3,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = seq_detect_pkg::DEFAULT_PAT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [PAT_W-1:0]                         cfg_pattern,
    input  logic [seq_detect_pkg::len_w(PAT_W)-1:0]  cfg_len,
    input  logic                                     cfg_overlap,
    output logic                                     cfg_err,
    input  logic                                     start,
    input  logic                                     stop,
    input  logic                                     bit_valid,
    input  logic                                     bit_in,
    output logic                                     busy,
    output logic                                     tone,
    output logic [CNT_W-1:0]                         count,
    output logic                                     count_ovf
`ifdef SEQ_DETECT_CTRL_THRESH_EN
    ,
    input  logic [CNT_W-1:0]                         cfg_thresh,
    output logic                                     irq
`endif
);

    import seq_detect_pkg::*;

    localparam int               LEN_W   = len_w(PAT_W);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] count_inc;
    logic             arm;
    logic             disarm;
    logic             cfg_wr;
    logic             cfg_legal;
    logic             m_en;
    logic             m_clr;
    logic             match;

`ifdef SEQ_DETECT_CTRL_THRESH_EN
    logic [CNT_W-1:0] thresh_q;
`endif

    assign arm       = (state == IDLE) && start && !stop;
    assign disarm    = (state == ARMED) && stop;
    assign cfg_wr    = cfg_valid && (state == IDLE);
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    // A bit arriving together with stop is dropped; stop wins.
    assign m_en      = (state == ARMED) && !stop && bit_valid;
    assign m_clr     = arm || disarm || (match && !overlap_q);
    assign count_inc = count + 1'b1;

    seq_matcher #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .en      (m_en),
        .bit_in  (bit_in),
        .clr     (m_clr),
        .pattern (pat_q),
        .len     (len_q),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= DEFAULT_PAT;
            len_q     <= LEN_MAX;
            overlap_q <= 1'b1;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
            tone      <= 1'b0;
            count     <= '0;
            count_ovf <= 1'b0;
`ifdef SEQ_DETECT_CTRL_THRESH_EN
            thresh_q  <= '0;
            irq       <= 1'b0;
`endif
        end else begin
            tone    <= match;
            cfg_err <= cfg_wr && !cfg_legal;
            if (cfg_wr && cfg_legal) begin
                pat_q     <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
`ifdef SEQ_DETECT_CTRL_THRESH_EN
                thresh_q  <= cfg_thresh;
`endif
            end
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= ARMED;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        count     <= '0;
                        count_ovf <= 1'b0;
`ifdef SEQ_DETECT_CTRL_THRESH_EN
                        irq       <= 1'b0;
`endif
                    end
                end
                ARMED: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (match) begin
                        count <= count_inc;
                        if (&count) begin
                            count_ovf <= 1'b1;
                        end
`ifdef SEQ_DETECT_CTRL_THRESH_EN
                        if ((thresh_q != '0) && (count_inc == thresh_q)) begin
                            irq <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
